// File: rtl/barrett_mod_mult.sv
// Pipelined Barrett modular multiplier/reducer with a runtime-loadable modulus.
// Three stages: operand capture, quotient estimate, remainder with one correction.
`timescale 1ns/1ps
module barrett_mod_mult #(
  parameter int DATA_WIDTH    = 16,
  parameter int MODULUS_WIDTH = 14,
  parameter int MU_WIDTH      = MODULUS_WIDTH + 2,
  parameter int TAG_WIDTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [DATA_WIDTH-1:0]   a_in,
  input  logic [DATA_WIDTH-1:0]   b_in,
  input  logic [2*DATA_WIDTH-1:0] s_in,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   result,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic [DATA_WIDTH-1:0]   cfg_modulus,
  input  logic [MU_WIDTH-1:0]     cfg_mu,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic                    configured
);

  localparam int XW       = 2 * DATA_WIDTH;
  localparam int SHIFT_LO = MODULUS_WIDTH - 2;
  localparam int SHIFT_HI = MODULUS_WIDTH + 3;
  localparam int XSW      = XW - SHIFT_LO;
  localparam int PW       = XSW + MU_WIDTH;
  localparam int QW       = PW - SHIFT_HI;
  localparam int QMW      = QW + DATA_WIDTH;
  localparam int RW       = ((QMW > XW) ? QMW : XW) + 1;

  typedef enum logic [1:0] {UNCFG, RUN, DRAIN} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   mod_reg;
  logic [MU_WIDTH-1:0]     mu_reg;
  logic                    configured_reg;

  logic                    valid_s1_reg, valid_s2_reg, valid_s3_reg;
  logic [XW-1:0]           x_s1_reg;
  logic                    mode_s1_reg;
  logic [TAG_WIDTH-1:0]    tag_s1_reg;
  logic [XW-1:0]           x_s2_reg;
  logic [QW-1:0]           q_s2_reg;
  logic [TAG_WIDTH-1:0]    tag_s2_reg;
  logic [DATA_WIDTH-1:0]   res_s3_reg;
  logic [TAG_WIDTH-1:0]    tag_s3_reg;

  logic                    advance, accept, any_valid, load_cfg;
  logic [XW-1:0]           prod, x_s2_next;
  logic [XSW-1:0]          x_hi;
  logic [PW-1:0]           qp;
  logic [QW-1:0]           q_s2_next;
  logic [RW-1:0]           qm, r, m_ext;
  logic [DATA_WIDTH-1:0]   res_s3_next;

  // The whole pipeline freezes only when the output register is full and not taken.
  assign advance   = ~(valid_s3_reg & ~out_ready);
  assign accept    = in_valid & in_ready;
  assign any_valid = valid_s1_reg | valid_s2_reg | valid_s3_reg;
  assign load_cfg  = cfg_valid & cfg_ready;

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= UNCFG;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      UNCFG:   if (cfg_valid) state_next = RUN;
      RUN:     if (cfg_valid && !cfg_ready) state_next = DRAIN;
      DRAIN:   if (!cfg_valid || cfg_ready) state_next = RUN;
      default: state_next = UNCFG;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    case (state_reg)
      UNCFG: cfg_ready = 1'b1;
      RUN: begin
        in_ready  = advance;
        cfg_ready = ~any_valid & ~in_valid;
      end
      DRAIN:   cfg_ready = ~any_valid;
      default: cfg_ready = 1'b0;
    endcase
  end

  // Stage 2: form X (product or direct value) and estimate the quotient.
  always_comb begin
    prod      = {{DATA_WIDTH{1'b0}}, x_s1_reg[XW-1:DATA_WIDTH]} *
                {{DATA_WIDTH{1'b0}}, x_s1_reg[DATA_WIDTH-1:0]};
    x_s2_next = mode_s1_reg ? prod : x_s1_reg;
    x_hi      = XSW'(x_s2_next >> SHIFT_LO);
    qp        = {{MU_WIDTH{1'b0}}, x_hi} * {{XSW{1'b0}}, mu_reg};
    q_s2_next = QW'(qp >> SHIFT_HI);
  end

  // Stage 3: remainder; the quotient estimate is at most one short, so one subtraction fixes it.
  always_comb begin
    qm          = {{(RW-QW){1'b0}}, q_s2_reg} * {{(RW-DATA_WIDTH){1'b0}}, mod_reg};
    m_ext       = {{(RW-DATA_WIDTH){1'b0}}, mod_reg};
    r           = {{(RW-XW){1'b0}}, x_s2_reg} - qm;
    res_s3_next = DATA_WIDTH'((r >= m_ext) ? (r - m_ext) : r);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_s1_reg   <= 1'b0;
      valid_s2_reg   <= 1'b0;
      valid_s3_reg   <= 1'b0;
      x_s1_reg       <= '0;
      mode_s1_reg    <= 1'b0;
      tag_s1_reg     <= '0;
      x_s2_reg       <= '0;
      q_s2_reg       <= '0;
      tag_s2_reg     <= '0;
      res_s3_reg     <= '0;
      tag_s3_reg     <= '0;
      mod_reg        <= '0;
      mu_reg         <= '0;
      configured_reg <= 1'b0;
    end else begin
      if (advance) begin
        valid_s1_reg <= accept;
        if (accept) begin
          // Multiplicands share the X register; mode tells stage 2 how to read it.
          x_s1_reg    <= mode ? {a_in, b_in} : s_in;
          mode_s1_reg <= mode;
          tag_s1_reg  <= in_tag;
        end
        valid_s2_reg <= valid_s1_reg;
        x_s2_reg     <= x_s2_next;
        q_s2_reg     <= q_s2_next;
        tag_s2_reg   <= tag_s1_reg;
        valid_s3_reg <= valid_s2_reg;
        res_s3_reg   <= res_s3_next;
        tag_s3_reg   <= tag_s2_reg;
      end
      if (load_cfg) begin
        mod_reg        <= cfg_modulus;
        mu_reg         <= cfg_mu;
        configured_reg <= 1'b1;
      end
    end
  end

  assign result     = res_s3_reg;
  assign out_tag    = tag_s3_reg;
  assign out_valid  = valid_s3_reg;
  assign configured = configured_reg;

endmodule

// File: tb/tb_barrett_mod_mult.sv
// Self-checking bench: random and directed operations scored against X mod M.
`timescale 1ns/1ps
module tb_barrett_mod_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;
  logic [31:0] s_in = '0;
  logic [3:0]  in_tag = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] result;
  logic [3:0]  out_tag;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] cfg_modulus = '0;
  logic [16:0] cfg_mu = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        configured;

  // mu for the 13-bit modulus 7681 needs 17 bits with k=14.
  barrett_mod_mult #(.DATA_WIDTH(16), .MODULUS_WIDTH(14), .MU_WIDTH(17), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .a_in(a_in), .b_in(b_in), .s_in(s_in),
    .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_modulus(cfg_modulus), .cfg_mu(cfg_mu), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .configured(configured)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned res;
    int unsigned tag;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          n_out = 0;
  int unsigned model_m = 0;
  bit          lat_chk = 1'b0;
  int          rdy_mode = 0;
  bit          hold_v = 1'b0;
  logic [15:0] hold_res;
  logic [3:0]  hold_tag;
  logic [15:0] last_res = '0;
  logic [3:0]  last_tag = '0;
  int unsigned mods[5] = '{12289, 7681, 8193, 16381, 9973};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  function automatic int unsigned calc_mu(input int unsigned m);
    return (32'd1 << 29) / m;
  endfunction

  always @(posedge clk) cyc++;

  // out_ready driver: 0 = held high, 1 = held low, 2 = random.
  always begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: handshakes are observed mid-cycle; expected results come from plain X mod M.
  always @(negedge clk) begin
    longint unsigned x;
    exp_t e;
    if (!rst) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        check_eq("xfer_excl", 64'(in_valid && in_ready), 0);
        model_m = cfg_modulus;
      end
      if (in_valid && in_ready) begin
        if (model_m == 0) begin
          check_eq("accept_uncfg", 1, 0);
        end else begin
          x = mode ? longint'(a_in) * longint'(b_in) : longint'(s_in);
          e.res = int'(x % model_m);
          e.tag = in_tag;
          e.cyc = cyc;
          sb.push_back(e);
        end
      end
      if (hold_v) begin
        check_eq("hold_valid", 64'(out_valid), 1);
        check_eq("hold_res", result, hold_res);
        check_eq("hold_tag", out_tag, hold_tag);
      end
      hold_v = 1'b0;
      if (out_valid) begin
        if (!out_ready) begin
          check_eq("stall_in_ready", 64'(in_ready), 0);
          hold_v   = 1'b1;
          hold_res = result;
          hold_tag = out_tag;
        end else if (sb.size() == 0) begin
          check_eq("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          $display("out: tag=%0d result=%0d expected=%0d", out_tag, result, e.res);
          check_eq("result", result, 64'(e.res));
          check_eq("tag", out_tag, 64'(e.tag));
          if (lat_chk) check_eq("latency", 64'(cyc - e.cyc), 3);
          last_res = result;
          last_tag = out_tag;
          n_out++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic md, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] s, input logic [3:0] t);
    bit got = 1'b0;
    int n = 0;
    mode = md; a_in = a; b_in = b; s_in = s; in_tag = t; in_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!got) check_eq("send_timeout", 0, 1);
  endtask

  task automatic load_cfg(input int unsigned m);
    bit got = 1'b0;
    int n = 0;
    cfg_modulus = m[15:0];
    cfg_mu = calc_mu(m);
    cfg_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = cfg_ready;
      tick();
      n++;
    end
    cfg_valid = 1'b0;
    if (!got) check_eq("cfg_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check_eq("drain_empty", 64'(sb.size()), 0);
  endtask

  task automatic rand_op(input int unsigned m, input logic [3:0] t);
    if ($urandom_range(0, 1) == 1)
      send(1'b1, 16'($urandom_range(0, m - 1)), 16'($urandom_range(0, m - 1)), '0, t);
    else
      send(1'b0, '0, '0, $urandom % (m * m), t);
  endtask

  initial begin
    int unsigned m;
    int base;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_configured", 64'(configured), 0);
    check_eq("rst_in_ready", 64'(in_ready), 0);
    check_eq("rst_cfg_ready", 64'(cfg_ready), 1);
    tick();
    rst = 1'b1;
    tick();

    // Directed vectors with modulus 12289
    load_cfg(12289);
    @(negedge clk);
    check_eq("configured", 64'(configured), 1);
    tick();
    lat_chk = 1'b1;
    send(1'b1, 16'd12288, 16'd12288, '0, 4'd1);
    wait_idle();
    check_eq("sq_minus1", last_res, 1);
    send(1'b1, 16'd5000, 16'd7000, '0, 4'd5);
    wait_idle();
    check_eq("mul_5000_7000", last_res, 928);
    check_eq("mul_tag", last_tag, 5);
    send(1'b0, '0, '0, 32'd0, 4'd2);
    send(1'b0, '0, '0, 32'd12289, 4'd3);
    send(1'b0, '0, '0, 32'd12288, 4'd4);
    wait_idle();
    check_eq("s_12288", last_res, 12288);
    lat_chk = 1'b0;

    // Stream of 8 with a 4-cycle output stall in the middle
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) rand_op(12289, 4'(i + 8));
      end
      begin
        repeat (3) tick();
        rdy_mode = 1;
        repeat (4) tick();
        rdy_mode = 0;
      end
    join
    wait_idle();
    check_eq("stall_count", 64'(n_out - base), 8);

    // Reconfigure with two operations in flight
    send(1'b1, 16'd12000, 16'd11000, '0, 4'd6);
    send(1'b0, '0, '0, 32'd100000000, 4'd7);
    cfg_modulus = 16'd7681;
    cfg_mu = 17'd69895;
    cfg_valid = 1'b1;
    @(negedge clk);
    check_eq("busy_cfg_ready", 64'(cfg_ready), 0);
    tick();
    @(negedge clk);
    check_eq("drain_in_ready", 64'(in_ready), 0);
    tick();
    load_cfg(7681);
    send(1'b1, 16'd7680, 16'd7680, '0, 4'd9);
    wait_idle();
    check_eq("mod7681_sq", last_res, 1);

    // Random traffic with random back-pressure and occasional reconfiguration
    rdy_mode = 2;
    m = 7681;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        m = mods[$urandom_range(0, 4)];
        load_cfg(m);
      end
      repeat ($urandom_range(0, 2)) tick();
      rand_op(m, 4'($urandom));
    end
    rdy_mode = 0;
    wait_idle();

    // Reset with the pipeline full
    for (int i = 0; i < 3; i++) rand_op(m, 4'(i));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mode = 1'b0; s_in = 32'd5; in_tag = 4'd1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("postrst_out_valid", 64'(out_valid), 0);
      check_eq("postrst_configured", 64'(configured), 0);
      check_eq("postrst_in_ready", 64'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    load_cfg(12289);
    send(1'b1, 16'd3, 16'd4, '0, 4'd2);
    wait_idle();
    check_eq("postrst_op", last_res, 12);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
